// File: rtl/lt24_poller_pkg.sv
// Shared types and helpers for the LT24 ADC BUSY poller.
package lt24_poller_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        LAT,
        GAP
    } poll_state_e;

    // The BUSY PIO exposes its data register at word 0
    localparam logic [1:0] BUSY_PIO_ADDR = 2'd0;

    // clog2 that never returns 0, so a counter is always at least 1 bit wide
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/lt24_adc_busy_poller_if.sv
// Avalon-MM read-only bus between the poller (master) and the BUSY PIO (slave).
interface lt24_adc_busy_poller_if;

    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );

endinterface

// File: rtl/lt24_gap_timer.sv
// Loadable down-counter with a zero flag; times both read latency and the poll gap.
module lt24_gap_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    // Load wins over counting; the counter parks at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/lt24_adc_busy_poller.sv
// Avalon-MM master polling the LT24 ADC BUSY PIO until the busy flag clears or
// MAX_POLLS reads have all returned busy.
// Optional feature macro: LT24_POLLER_IRQ_EN adds a sticky irq output with irq_ack.
module lt24_adc_busy_poller
    import lt24_poller_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned POLL_GAP     = 4,
    parameter int unsigned MAX_POLLS    = 8,
    parameter int unsigned BUSY_BIT     = 0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  abort,
    lt24_adc_busy_poller_if.master                avm,
    output logic                                  active,
    output logic                                  done,
    output logic                                  timeout,
    output logic [clog2_min1(MAX_POLLS+1)-1:0]    poll_count
`ifdef LT24_POLLER_IRQ_EN
    ,
    output logic                                  irq,
    input  logic                                  irq_ack
`endif
);

    localparam int unsigned CNT_W   = clog2_min1(MAX_POLLS + 1);
    localparam int unsigned TMR_MAX = (READ_LATENCY > POLL_GAP) ? READ_LATENCY : POLL_GAP;
    localparam int unsigned TMR_W   = clog2_min1(TMR_MAX);

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_POLLS);
    localparam logic [TMR_W-1:0] LAT_LOAD = TMR_W'(READ_LATENCY - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'((POLL_GAP == 0) ? 0 : POLL_GAP - 1);

    poll_state_e      state;
    logic             abort_pend;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_value;
    logic             tmr_zero;
    logic             busy_flag;
    logic [CNT_W-1:0] count_inc;
    logic             unused_readdata;

    assign busy_flag       = avm.avm_readdata[BUSY_BIT];
    assign unused_readdata = ^avm.avm_readdata;
    assign count_inc       = (poll_count == MAX_CNT) ? poll_count : poll_count + 1'b1;

    // Timer loads the latency on read acceptance and the gap length on the sample edge
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = LAT_LOAD;
        if (state == READ && !avm.avm_waitrequest) begin
            tmr_load  = 1'b1;
            tmr_value = LAT_LOAD;
        end else if (state == LAT && tmr_zero) begin
            tmr_load  = 1'b1;
            tmr_value = GAP_LOAD;
        end
    end

    lt24_gap_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .zero       (tmr_zero)
    );

    // Poll sequencing with registered done/timeout pulses and read counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            abort_pend <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            poll_count <= '0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    abort_pend <= 1'b0;
                    if (start && !abort) begin
                        poll_count <= '0;
                        state      <= READ;
                    end
                end
                READ: begin
                    // An accepted read must still drain its latency before aborting
                    if (abort) abort_pend <= 1'b1;
                    if (!avm.avm_waitrequest) state <= LAT;
                end
                LAT: begin
                    if (abort) abort_pend <= 1'b1;
                    if (tmr_zero) begin
                        poll_count <= count_inc;
                        if (abort || abort_pend) begin
                            state <= IDLE;
                        end else if (!busy_flag) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else if (count_inc == MAX_CNT) begin
                            timeout <= 1'b1;
                            state   <= IDLE;
                        end else if (POLL_GAP == 0) begin
                            state <= READ;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (tmr_zero) begin
                        state <= READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign avm.avm_read    = (state == READ);
    assign avm.avm_address = BUSY_PIO_ADDR;
    assign active          = (state != IDLE);

`ifdef LT24_POLLER_IRQ_EN
    logic irq_q;

    // Sticky interrupt; a new pulse overrides a coincident acknowledge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (irq_q & ~irq_ack) | done | timeout;
        end
    end

    assign irq = irq_q | done | timeout;
`endif

endmodule
